bcd7_blink_display: RTL and testbench



---
 rtl/bcd7_blink_display_if.sv | 11 +
 rtl/bcd7_blink_display.sv | 66 ++++++
 tb/tb_bcd7_blink_display.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bcd7_blink_display_if.sv
// Display bus for bcd7_blink_display: nibble/mode in, segment pattern and blink LED out.
// The producer (counter/status logic) takes the master side; the driver takes the slave side.
interface bcd7_blink_display_if;
   logic [3:0] i_val;
   logic       i_dec;
   logic [6:0] o_seg;
   logic       o_led;

   modport master (output i_val, output i_dec, input o_seg, input o_led);
   modport slave  (input i_val, input i_dec, output o_seg, output o_led);
endinterface

// File: rtl/bcd7_blink_display.sv
// Registered nibble-to-7-segment driver with a free-running blink divider for a status LED.
// Build option SEG_ACTIVE_LOW_EN: invert segment drive for common-anode displays (off = 7'h7F).
module bcd7_blink_display #(
   parameter int CBITS = 22
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   bcd7_blink_display_if.slave  bus
);

`ifdef SEG_ACTIVE_LOW_EN
   localparam logic [6:0] SEG_POL = 7'h7F;
`else
   localparam logic [6:0] SEG_POL = 7'h00;
`endif

   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [6:0]       seg_q, seg_d;
   logic [6:0]       pat;

   // Active-high pattern, bit0=a .. bit6=g
   always_comb begin
      pat = 7'h00;
      case (bus.i_val)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         4'hF: pat = 7'h71;
         default: pat = 7'h00;
      endcase
      if (bus.i_dec && (bus.i_val >= 4'd10)) begin
         pat = 7'h00;
      end
   end

   always_comb begin
      seg_d = pat ^ SEG_POL;
      cnt_d = cnt_q + {{(CBITS-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
         seg_q <= SEG_POL;
      end else begin
         cnt_q <= cnt_d;
         seg_q <= seg_d;
      end
   end

   assign bus.o_seg = seg_q;
   assign bus.o_led = cnt_q[CBITS-1];

endmodule

// File: tb/tb_bcd7_blink_display.sv
// Directed bench for bcd7_blink_display with CBITS=4 (blink period 16 clocks).
module tb_bcd7_blink_display;

`ifdef SEG_ACTIVE_LOW_EN
   localparam logic [6:0] SEG_POL = 7'h7F;
`else
   localparam logic [6:0] SEG_POL = 7'h00;
`endif

   logic i_clk;
   logic i_rst_n;
   int   n_cmp;
   int   n_err;

   logic [6:0] hex_tab [16];

   bcd7_blink_display_if bus ();

   bcd7_blink_display #(.CBITS(4)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

      // reset held for 3 clocks with a lit-pattern input
      i_rst_n   = 1'b0;
      bus.i_val = 4'd8;
      bus.i_dec = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_seg", {25'd0, bus.o_seg}, {25'd0, SEG_POL});
         chk("rst_led", {31'd0, bus.o_led}, 32'd0);
      end
      i_rst_n = 1'b1;
      tick();
      chk("rel_seg", {25'd0, bus.o_seg}, {25'd0, 7'h7F ^ SEG_POL});

      // hex sweep
      bus.i_dec = 1'b0;
      for (int v = 0; v < 16; v++) begin
         bus.i_val = v[3:0];
         tick();
         chk($sformatf("hex_%0d", v), {25'd0, bus.o_seg}, {25'd0, hex_tab[v] ^ SEG_POL});
      end

      // decimal mode blanking
      bus.i_dec = 1'b1;
      bus.i_val = 4'd9;
      tick();
      chk("dec_9", {25'd0, bus.o_seg}, {25'd0, 7'h6F ^ SEG_POL});
      for (int v = 10; v < 16; v++) begin
         bus.i_val = v[3:0];
         tick();
         chk($sformatf("dec_blank_%0d", v), {25'd0, bus.o_seg}, {25'd0, SEG_POL});
      end
      bus.i_val = 4'd0;
      tick();
      chk("dec_0", {25'd0, bus.o_seg}, {25'd0, 7'h3F ^ SEG_POL});

      // 5-bit count {i_dec,i_val}: hex table, then 0-9 plus six blanks
      for (int c = 0; c < 32; c++) begin
         logic [4:0] cv;
         logic [6:0] e;
         cv = c[4:0];
         bus.i_dec = cv[4];
         bus.i_val = cv[3:0];
         e = (cv[4] && (cv[3:0] >= 4'd10)) ? 7'h00 : hex_tab[cv[3:0]];
         tick();
         chk($sformatf("cnt5_%0d", c), {25'd0, bus.o_seg}, {25'd0, e ^ SEG_POL});
      end

      // blink: after n edges from release, led = bit 3 of n
      bus.i_dec = 1'b0;
      bus.i_val = 4'd8;
      i_rst_n = 1'b0;
      #2;
      i_rst_n = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         logic [5:0] nv;
         nv = n[5:0];
         tick();
         chk($sformatf("blink_%0d", n), {31'd0, bus.o_led}, {31'd0, nv[3]});
      end

      // async reset mid-run at cycle 13
      i_rst_n = 1'b0;
      #2;
      i_rst_n = 1'b1;
      for (int n = 1; n <= 13; n++) tick();
      chk("pre_async_led", {31'd0, bus.o_led}, 32'd1);
      chk("pre_async_seg", {25'd0, bus.o_seg}, {25'd0, 7'h7F ^ SEG_POL});
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("async_led", {31'd0, bus.o_led}, 32'd0);
      chk("async_seg", {25'd0, bus.o_seg}, {25'd0, SEG_POL});
      tick();
      chk("async_hold_led", {31'd0, bus.o_led}, 32'd0);
      bus.i_val = 4'd2;
      #2;
      i_rst_n = 1'b1;
      tick();
      chk("post_rel_seg", {25'd0, bus.o_seg}, {25'd0, 7'h5B ^ SEG_POL});
      chk("post_rel_led_1", {31'd0, bus.o_led}, 32'd0);
      for (int n = 2; n <= 17; n++) begin
         logic [5:0] nv;
         nv = n[5:0];
         tick();
         chk($sformatf("reblink_%0d", n), {31'd0, bus.o_led}, {31'd0, nv[3]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
